// File: rtl/peek_dump_sequencer.sv
// peek_dump_sequencer: walks every core's data RAM through the NoC peek port
// and serialises a base_addr/word_count window of each core into a byte stream.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a dump (accepted in IDLE only)
//   base_addr         first RAM address per core, latched on start
//   word_count        words per core, latched on start (0 = headers only)
//   peekAddress       registered RAM address to the NoC top level
//   peekId            registered core select to the NoC top level
//   peekData          RAM word returned PEEK_LAT cycles after a peek change
//   tx_data/tx_valid  byte stream out; transfer when tx_valid && tx_ready
//   tx_ready          sink ready
//   busy              high outside IDLE
//   done              one-cycle pulse after the trailer byte transfers

module peek_dump_sequencer #(
    parameter int RN       = 16,
    parameter int CNT_W    = 16,
    parameter int PEEK_LAT = 1,
    localparam int ID_W    = (RN > 1) ? $clog2(RN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic [31:0]      peekAddress,
    output logic [ID_W-1:0]  peekId,
    input  logic [31:0]      peekData,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WAIT,
        S_CAP,
        S_BYTE,
        S_TRL
    } state_t;

    localparam logic [2:0] LAT0 = 3'(PEEK_LAT);

    state_t           state;
    logic [31:0]      base_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ID_W-1:0]  core;
    logic [31:0]      addr;
    logic [CNT_W-1:0] left;
    logic [2:0]       lat;
    logic [31:0]      shreg;
    logic [1:0]       idx;

    logic             xfer;
    logic             last_core;
    logic [ID_W-1:0]  core_nxt;
    logic [7:0]       hdr_nxt;
    logic [31:0]      addr_inc;
    logic [CNT_W-1:0] left_dec;

    assign xfer      = tx_valid && tx_ready;
    assign last_core = (core == ID_W'(RN - 1));
    assign core_nxt  = core + ID_W'(1);
    assign hdr_nxt   = {4'hA, 4'(core_nxt)};
    assign addr_inc  = addr + 32'd1;
    assign left_dec  = left - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            core        <= '0;
            addr        <= '0;
            left        <= '0;
            lat         <= '0;
            shreg       <= '0;
            idx         <= '0;
            peekAddress <= '0;
            peekId      <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        cnt_q    <= word_count;
                        core     <= '0;
                        addr     <= base_addr;
                        left     <= word_count;
                        tx_data  <= 8'hA0;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_HDR;
                    end
                end

                S_HDR: begin
                    if (xfer) begin
                        if (left != '0) begin
                            tx_valid    <= 1'b0;
                            peekId      <= core;
                            peekAddress <= addr;
                            lat         <= LAT0;
                            state       <= S_WAIT;
                        end else if (last_core) begin
                            tx_data <= 8'h5A;
                            state   <= S_TRL;
                        end else begin
                            core    <= core_nxt;
                            addr    <= base_q;
                            left    <= cnt_q;
                            tx_data <= hdr_nxt;
                        end
                    end
                end

                // Peek outputs settled on entry; hold for PEEK_LAT+1 cycles.
                S_WAIT: begin
                    if (lat == 3'd0) begin
                        state <= S_CAP;
                    end else begin
                        lat <= lat - 3'd1;
                    end
                end

                S_CAP: begin
                    shreg    <= peekData;
                    tx_data  <= peekData[7:0];
                    tx_valid <= 1'b1;
                    idx      <= 2'd0;
                    state    <= S_BYTE;
                end

                S_BYTE: begin
                    if (xfer) begin
                        shreg   <= shreg >> 8;
                        tx_data <= shreg[15:8];
                        idx     <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            addr <= addr_inc;
                            left <= left_dec;
                            if (left_dec != '0) begin
                                tx_valid    <= 1'b0;
                                peekId      <= core;
                                peekAddress <= addr_inc;
                                lat         <= LAT0;
                                state       <= S_WAIT;
                            end else if (last_core) begin
                                tx_data <= 8'h5A;
                                state   <= S_TRL;
                            end else begin
                                core    <= core_nxt;
                                addr    <= base_q;
                                left    <= cnt_q;
                                tx_data <= hdr_nxt;
                                state   <= S_HDR;
                            end
                        end
                    end
                end

                S_TRL: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peek_dump_sequencer.sv
// Bench for peek_dump_sequencer: three instances (PEEK_LAT 1, 0, 3) share
// stimulus; a negedge monitor scores every transferred byte against a queue.

module tb_peek_dump_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [15:0] cnt = '0;
    logic        tx_ready = 1'b1;
    logic        bp_en = 1'b0;
    logic        clr = 1'b0;

    logic [31:0] pa  [3];
    logic [3:0]  pid [3];
    logic [31:0] pd  [3];
    logic [7:0]  txd [3];
    logic        txv [3];
    logic        bsy [3];
    logic        dn  [3];

    logic [7:0]  exp_q [$];
    logic [7:0]  log0 [$];
    int          nb [3];
    int          rd [3];
    int          donec [3];
    logic        stall [3];
    logic [7:0]  sd [3];
    logic [7:0]  last_b [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        logic [31:0] ram_now;
        logic [31:0] pipe [8];
        assign ram_now = {4'b0, pid[g], 24'b0} | pa[g];
        always @(posedge clk) begin
            pipe[0] <= ram_now;
            for (int j = 1; j < 8; j++) pipe[j] <= pipe[j-1];
        end
        if (L == 0) begin : g_l0
            assign pd[g] = ram_now;
        end else begin : g_ln
            assign pd[g] = pipe[L-1];
        end
        peek_dump_sequencer #(
            .RN(16), .CNT_W(16), .PEEK_LAT(L)
        ) dut (
            .clk(clk), .rst(rst), .start(start),
            .base_addr(base), .word_count(cnt),
            .peekAddress(pa[g]), .peekId(pid[g]), .peekData(pd[g]),
            .tx_data(txd[g]), .tx_valid(txv[g]), .tx_ready(tx_ready),
            .busy(bsy[g]), .done(dn[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (clr) begin
            log0.delete();
            for (int i = 0; i < 3; i++) begin
                nb[i] = 0; rd[i] = 0; donec[i] = 0;
                stall[i] = 1'b0; last_b[i] = 8'h00;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (stall[i] && !rst) begin
                    chk($sformatf("stall_valid[%0d]", i), 32'(txv[i]), 32'd1);
                    chk($sformatf("stall_data[%0d]", i), 32'(txd[i]), 32'(sd[i]));
                end
                if (txv[i] && tx_ready && !rst) begin
                    if (i == 0) log0.push_back(txd[i]);
                    chk($sformatf("byte[%0d] #%0d", i, nb[i]), 32'(txd[i]),
                        (rd[i] < exp_q.size()) ? 32'(exp_q[rd[i]]) : 32'hDEAD);
                    nb[i]++; rd[i]++;
                    last_b[i] = txd[i];
                end
                if (dn[i]) begin
                    donec[i]++;
                    chk($sformatf("done_busy[%0d]", i), 32'(bsy[i]), 32'd0);
                    chk($sformatf("done_after_trl[%0d]", i), 32'(last_b[i]), 32'h5A);
                end
                stall[i] = txv[i] && !tx_ready && !rst;
                sd[i] = txd[i];
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic build(input logic [31:0] b, input logic [15:0] c);
        logic [31:0] a, d;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(8'hA0 | 8'(k));
            for (int w = 0; w < int'(c); w++) begin
                a = b + 32'(w);
                d = (32'(k) << 24) | a;
                for (int s = 0; s < 4; s++) exp_q.push_back(8'(d >> (8 * s)));
            end
        end
        exp_q.push_back(8'h5A);
    endtask

    task automatic sb_clear();
        exp_q.delete();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic go(input logic [31:0] b, input logic [15:0] c);
        base = b;
        cnt = c;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int nd, input int nbytes,
                             input int budget);
        int t = 0;
        while ((donec[0] < nd || donec[1] < nd || donec[2] < nd) && t < budget) begin
            cyc();
            t++;
        end
        chk({nm, " timeout"}, 32'(t < budget), 32'd1);
        cyc(3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s bytes[%0d]", nm, i), 32'(nb[i]), 32'(nbytes));
            chk($sformatf("%s dones[%0d]", nm, i), 32'(donec[i]), 32'(nd));
            chk($sformatf("%s idle[%0d]", nm, i), 32'(bsy[i]), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] core3 [9];
        core3 = '{8'hA3, 8'h10, 8'h00, 8'h00, 8'h03, 8'h11, 8'h00, 8'h00, 8'h03};

        cyc(2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst tx_valid[%0d]", i), 32'(txv[i]), 32'd0);
            chk($sformatf("rst tx_data[%0d]", i), 32'(txd[i]), 32'd0);
            chk($sformatf("rst peekAddress[%0d]", i), pa[i], 32'd0);
            chk($sformatf("rst peekId[%0d]", i), 32'(pid[i]), 32'd0);
            chk($sformatf("rst busy[%0d]", i), 32'(bsy[i]), 32'd0);
            chk($sformatf("rst done[%0d]", i), 32'(dn[i]), 32'd0);
        end
        rst = 1'b0;
        cyc();

        // Basic dump, also checks one-edge start-to-header latency
        sb_clear();
        build(32'h10, 16'd2);
        go(32'h10, 16'd2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hdr latency[%0d]", i), 32'(txv[i]), 32'd1);
            chk($sformatf("hdr byte[%0d]", i), 32'(txd[i]), 32'hA0);
            chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'd1);
        end
        wait_done("basic", 1, 145, 3000);
        for (int j = 0; j < 9; j++)
            chk($sformatf("core3 byte %0d", j), 32'(log0[27 + j]), 32'(core3[j]));
        chk("basic trailer", 32'(log0[144]), 32'h5A);

        // Zero words, then a start in the done cycle
        sb_clear();
        build(32'h10, 16'd0);
        build(32'h10, 16'd0);
        go(32'h10, 16'd0);
        begin
            int t = 0;
            while (!dn[0] && t < 200) begin
                cyc();
                t++;
            end
            chk("zero done seen", 32'(dn[0]), 32'd1);
        end
        go(32'h10, 16'd0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b hdr[%0d]", i), 32'(txv[i] && txd[i] == 8'hA0), 32'd1);
        wait_done("zero", 2, 34, 500);
        chk("zero last hdr", 32'(log0[15]), 32'hAF);

        // Random back-pressure
        sb_clear();
        build(32'h10, 16'd2);
        bp_en = 1'b1;
        go(32'h10, 16'd2);
        wait_done("backpressure", 1, 145, 10000);
        bp_en = 1'b0;
        cyc(2);

        // Address wrap
        sb_clear();
        build(32'hFFFF_FFFF, 16'd2);
        go(32'hFFFF_FFFF, 16'd2);
        wait_done("wrap", 1, 145, 3000);
        chk("wrap core1 w1", {log0[17], log0[16], log0[15], log0[14]}, 32'h0100_0000);
        chk("wrap core1 w0", {log0[13], log0[12], log0[11], log0[10]}, 32'hFFFF_FFFF);

        // Start while busy is ignored
        sb_clear();
        build(32'h10, 16'd2);
        go(32'h10, 16'd2);
        cyc(40);
        go(32'h99, 16'd5);
        cyc(20);
        go(32'h77, 16'd1);
        wait_done("busy start", 1, 145, 3000);

        // Reset after the 2nd byte of core 5's first word
        sb_clear();
        build(32'h10, 16'd2);
        go(32'h10, 16'd2);
        begin
            int t = 0;
            while (nb[0] < 48 && t < 3000) begin
                cyc();
                t++;
            end
            chk("reach core5", 32'(nb[0]), 32'd48);
        end
        chk("core5 word byte1", 32'(log0[47]), 32'h00);
        rst = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst tx_valid[%0d]", i), 32'(txv[i]), 32'd0);
            chk($sformatf("midrst busy[%0d]", i), 32'(bsy[i]), 32'd0);
            chk($sformatf("midrst done[%0d]", i), 32'(dn[i]), 32'd0);
        end
        rst = 1'b0;
        cyc(5);
        chk("midrst no done", 32'(donec[0]), 32'd0);
        chk("midrst no valid", 32'(txv[0]), 32'd0);
        sb_clear();
        build(32'h10, 16'd2);
        go(32'h10, 16'd2);
        wait_done("restart", 1, 145, 3000);
        chk("restart first", 32'(log0[0]), 32'hA0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
